// File: rtl/npc_pkg.sv
// Shared types and constants for the npc control sequencer.
package npc_pkg;

   typedef enum logic [2:0] {
      StFetch,
      StIwait,
      StExec,
      StMem,
      StMwait,
      StHalt
   } ctrl_state_t;

   localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
   localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;

endpackage

// File: rtl/npc_perf_cnt.sv
// 64-bit free-running event counter with synchronous clear and count enable.
module npc_perf_cnt (
   input  logic        i_clk,
   input  logic        i_clr,
   input  logic        i_en,
   output logic [63:0] o_cnt
);

   logic [63:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 64'd1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle control sequencer: owns the PC, sequences fetch/execute/memory
// handshakes, gates RF/PC writes and halts on ebreak or a misaligned next PC.
module npc_ctrl
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   output logic        ifu_rsp_ready,
   input  logic        dec_reg_wen,
   input  logic        dec_is_mem,
   input  logic [31:0] next_pc,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   input  logic        lsu_rsp_valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        rf_wen,
   output logic        halted,
   output logic        halt_err,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instret
);

   ctrl_state_t r_state, w_state_d;
   logic [31:0] r_pc, w_pc_d;
   logic [31:0] r_inst, w_inst_d;
   logic        r_halt_err, w_halt_err_d;
   logic        w_retire;
   logic        w_cyc_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StFetch;
         r_pc       <= RESET_PC;
         r_inst     <= '0;
         r_halt_err <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_inst     <= w_inst_d;
         r_halt_err <= w_halt_err_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_pc_d        = r_pc;
      w_inst_d      = r_inst;
      w_halt_err_d  = r_halt_err;
      w_retire      = 1'b0;
      ifu_req_valid = 1'b0;
      ifu_rsp_ready = 1'b0;
      lsu_req_valid = 1'b0;
      rf_wen        = 1'b0;
      case (r_state)
         StFetch: begin
            ifu_req_valid = 1'b1;
            if (ifu_req_ready) w_state_d = StIwait;
         end
         StIwait: begin
            ifu_rsp_ready = 1'b1;
            if (ifu_rsp_valid) begin
               w_inst_d  = ifu_rsp_inst;
               w_state_d = StExec;
            end
         end
         StExec: begin
            // ebreak retires but writes nothing; misalignment neither retires nor writes
            if (r_inst == INST_EBREAK) begin
               w_retire  = 1'b1;
               w_state_d = StHalt;
            end else if (next_pc[1:0] != 2'b00) begin
               w_halt_err_d = 1'b1;
               w_state_d    = StHalt;
            end else if (dec_is_mem) begin
               w_state_d = StMem;
            end else begin
               rf_wen    = dec_reg_wen;
               w_pc_d    = next_pc;
               w_retire  = 1'b1;
               w_state_d = StFetch;
            end
         end
         StMem: begin
            lsu_req_valid = 1'b1;
            if (lsu_req_ready) w_state_d = StMwait;
         end
         StMwait: begin
            if (lsu_rsp_valid) begin
               rf_wen    = dec_reg_wen;
               w_pc_d    = next_pc;
               w_retire  = 1'b1;
               w_state_d = StFetch;
            end
         end
         StHalt: begin
            w_state_d = StHalt;
         end
         default: begin
            w_state_d = StFetch;
         end
      endcase
      // The reset cycle may start in any state; keep all strobes quiet during it.
      if (rst) begin
         ifu_req_valid = 1'b0;
         ifu_rsp_ready = 1'b0;
         lsu_req_valid = 1'b0;
         rf_wen        = 1'b0;
         w_retire      = 1'b0;
      end
   end

   assign w_cyc_en     = (r_state != StHalt);
   assign ifu_req_addr = r_pc;
   assign pc           = r_pc;
   assign inst         = r_inst;
   assign halted       = (r_state == StHalt);
   assign halt_err     = r_halt_err;

   npc_perf_cnt u_cycle_cnt (
      .i_clk (clk),
      .i_clr (rst),
      .i_en  (w_cyc_en),
      .o_cnt (cycle_cnt)
   );

   npc_perf_cnt u_instret_cnt (
      .i_clk (clk),
      .i_clr (rst),
      .i_en  (w_retire),
      .o_cnt (instret)
   );

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: stimulus queues expected fetch/write/halt
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_npc_ctrl;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clk;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready;
   logic        ifu_rsp_valid;
   logic [31:0] ifu_rsp_inst;
   logic        ifu_rsp_ready;
   logic        dec_reg_wen;
   logic        dec_is_mem;
   logic [31:0] next_pc;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic        lsu_rsp_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        rf_wen;
   logic        halted;
   logic        halt_err;
   logic [63:0] cycle_cnt;
   logic [63:0] instret;

   npc_ctrl u_dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_req_ready (ifu_req_ready),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_inst  (ifu_rsp_inst),
      .ifu_rsp_ready (ifu_rsp_ready),
      .dec_reg_wen   (dec_reg_wen),
      .dec_is_mem    (dec_is_mem),
      .next_pc       (next_pc),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_rsp_valid (lsu_rsp_valid),
      .inst          (inst),
      .pc            (pc),
      .rf_wen        (rf_wen),
      .halted        (halted),
      .halt_err      (halt_err),
      .cycle_cnt     (cycle_cnt),
      .instret       (instret)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] ret;
      logic [63:0] cyc;
   } ev_exp_t;

   typedef struct packed {
      logic        err;
      logic [31:0] addr;
      logic [63:0] ret;
      logic [63:0] cyc;
   } halt_exp_t;

   ev_exp_t   fetch_q[$];
   ev_exp_t   wr_q[$];
   halt_exp_t halt_q[$];

   int checks = 0;
   int errors = 0;
   logic done = 1'b0;

   logic [31:0] m_pc;
   logic [63:0] m_ret;
   logic [63:0] m_cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- monitor
   logic        p_rst = 1'b1;
   logic        p_ifu_pend = 1'b0;
   logic [31:0] p_ifu_addr = '0;
   logic        p_lsu_pend = 1'b0;
   logic        p_rsp_hs = 1'b0;
   logic [31:0] p_rsp_inst = '0;
   logic [31:0] p_inst = '0;
   logic        p_halted = 1'b0;
   logic [63:0] frozen_cyc = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   always @(negedge clk) begin
      ev_exp_t   e;
      halt_exp_t h;
      if (rst) begin
         chk("rst_strobes", {60'd0, ifu_req_valid, ifu_rsp_ready, lsu_req_valid, rf_wen}, 64'd0);
         p_rst      = 1'b1;
         p_ifu_pend = 1'b0;
         p_lsu_pend = 1'b0;
         p_rsp_hs   = 1'b0;
         p_halted   = 1'b0;
      end else begin
         if (p_rst) begin
            chk("reset_pc", pc, RST_PC);
            chk("reset_ifu_req_valid", ifu_req_valid, 1);
            chk("reset_cycle_cnt", cycle_cnt, 0);
            chk("reset_instret", instret, 0);
            chk("reset_halt_flags", {halted, halt_err}, 0);
            chk("reset_inst", inst, 0);
         end else begin
            chk("inst_latch", inst, p_rsp_hs ? p_rsp_inst : p_inst);
         end
         if (p_ifu_pend) begin
            chk("ifu_valid_stable", ifu_req_valid, 1);
            chk("ifu_addr_stable", ifu_req_addr, p_ifu_addr);
         end
         if (p_lsu_pend) chk("lsu_valid_stable", lsu_req_valid, 1);
         if (ifu_req_valid && ifu_req_ready) begin
            if (fetch_q.size() == 0) begin
               unexpected("fetch_unexpected");
            end else begin
               e = fetch_q.pop_front();
               chk("fetch_addr", ifu_req_addr, e.addr);
               chk("fetch_instret", instret, e.ret);
               chk("fetch_cycle_cnt", cycle_cnt, e.cyc);
            end
         end
         if (rf_wen) begin
            if (wr_q.size() == 0) begin
               unexpected("rf_wen_unexpected");
            end else begin
               e = wr_q.pop_front();
               chk("wr_pc", pc, e.addr);
               chk("wr_instret", instret, e.ret);
               chk("wr_cycle_cnt", cycle_cnt, e.cyc);
            end
         end
         if (halted && !p_halted) begin
            if (halt_q.size() == 0) begin
               unexpected("halt_unexpected");
            end else begin
               h = halt_q.pop_front();
               frozen_cyc = h.cyc;
               chk("halt_err", halt_err, h.err);
               chk("halt_pc", pc, h.addr);
               chk("halt_instret", instret, h.ret);
               chk("halt_cycle_cnt", cycle_cnt, h.cyc);
            end
         end else if (halted) begin
            chk("halt_cycle_frozen", cycle_cnt, frozen_cyc);
            chk("halt_strobes", {60'd0, ifu_req_valid, ifu_rsp_ready, lsu_req_valid, rf_wen}, 0);
         end
         p_rst      = 1'b0;
         p_ifu_pend = ifu_req_valid && !ifu_req_ready;
         p_ifu_addr = ifu_req_addr;
         p_lsu_pend = lsu_req_valid && !lsu_req_ready;
         p_rsp_hs   = ifu_rsp_valid && ifu_rsp_ready;
         p_rsp_inst = ifu_rsp_inst;
         p_halted   = halted;
      end
      p_inst = inst;
      if (done) begin
         chk("fetch_q_left", fetch_q.size(), 0);
         chk("wr_q_left", wr_q.size(), 0);
         chk("halt_q_left", halt_q.size(), 0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   // -------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #2;
      m_cyc = m_cyc + 64'd1;
   endtask

   task automatic clear_inputs();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_inst  = '0;
      dec_reg_wen   = 1'b0;
      dec_is_mem    = 1'b0;
      next_pc       = '0;
      lsu_req_ready = 1'b0;
      lsu_rsp_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      clear_inputs();
      repeat (n) begin
         @(posedge clk);
         #2;
      end
      rst   = 1'b0;
      m_pc  = RST_PC;
      m_ret = '0;
      m_cyc = '0;
   endtask

   // Hammer every handshake input while halted; nothing may respond.
   task automatic halt_linger(input int n);
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      lsu_req_ready = 1'b1;
      lsu_rsp_valid = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
      clear_inputs();
   endtask

   task automatic run_instr(input logic [31:0] iw, input logic wen, input logic mem,
                            input logic [31:0] npc, input int req_stall, input int rsp_dly,
                            input int lreq_stall, input int lrsp_dly);
      ifu_rsp_inst = iw;
      dec_reg_wen  = wen;
      dec_is_mem   = mem;
      next_pc      = npc;
      fetch_q.push_back('{addr: m_pc, ret: m_ret, cyc: m_cyc + 64'(req_stall)});
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      repeat (req_stall) tick();
      // a zero-delay response already shows up in the FETCH cycle
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = (rsp_dly == 0);
      tick();
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      repeat (rsp_dly) tick();
      ifu_rsp_valid = 1'b1;
      tick();
      ifu_rsp_valid = 1'b0;
      if (iw == EBREAK) begin
         halt_q.push_back('{err: 1'b0, addr: m_pc, ret: m_ret + 64'd1, cyc: m_cyc + 64'd1});
         tick();
         m_ret = m_ret + 64'd1;
      end else if (npc[1:0] != 2'b00) begin
         halt_q.push_back('{err: 1'b1, addr: m_pc, ret: m_ret, cyc: m_cyc + 64'd1});
         tick();
      end else if (mem) begin
         tick();
         for (int i = 0; i < lreq_stall; i++) begin
            lsu_req_ready = 1'b0;
            lsu_rsp_valid = (i == 0);
            tick();
         end
         lsu_rsp_valid = 1'b0;
         lsu_req_ready = 1'b1;
         tick();
         lsu_req_ready = 1'b0;
         repeat (lrsp_dly) tick();
         if (wen) wr_q.push_back('{addr: m_pc, ret: m_ret, cyc: m_cyc});
         lsu_rsp_valid = 1'b1;
         tick();
         lsu_rsp_valid = 1'b0;
         m_pc  = npc;
         m_ret = m_ret + 64'd1;
      end else begin
         if (wen) wr_q.push_back('{addr: m_pc, ret: m_ret, cyc: m_cyc});
         tick();
         m_pc  = npc;
         m_ret = m_ret + 64'd1;
      end
   endtask

   initial begin
      rst   = 1'b1;
      m_pc  = RST_PC;
      m_ret = '0;
      m_cyc = '0;
      clear_inputs();
      do_reset(2);

      run_instr(32'h0050_0093, 1'b1, 1'b0, m_pc + 32'd4, 0, 0, 0, 0);
      run_instr(32'h0010_8113, 1'b1, 1'b0, m_pc + 32'd4, 0, 0, 0, 0);
      run_instr(32'h0020_0193, 1'b1, 1'b0, m_pc + 32'd4, 0, 0, 0, 0);
      run_instr(32'h0020_8233, 1'b1, 1'b0, m_pc + 32'd4, 4, 2, 0, 0);
      run_instr(32'h0000_a283, 1'b1, 1'b1, m_pc + 32'd4, 0, 0, 2, 2);
      run_instr(32'h0050_a223, 1'b0, 1'b1, m_pc + 32'd4, 0, 0, 0, 0);
      run_instr(32'h0100_00ef, 1'b1, 1'b0, m_pc + 32'd16, 0, 0, 0, 0);
      run_instr(32'h0000_0013, 1'b0, 1'b0, m_pc + 32'd4, 0, 1, 0, 0);
      run_instr(EBREAK, 1'b0, 1'b0, m_pc + 32'd4, 0, 0, 0, 0);
      halt_linger(4);
      do_reset(1);

      run_instr(32'h0010_0093, 1'b1, 1'b0, m_pc + 32'd4, 0, 0, 0, 0);
      run_instr(32'h0020_0113, 1'b1, 1'b0, 32'h8000_0006, 0, 0, 0, 0);
      halt_linger(3);
      do_reset(1);

      // Abandon a load while its LSU request is still pending.
      ifu_rsp_inst = 32'h0000_a103;
      dec_is_mem   = 1'b1;
      dec_reg_wen  = 1'b1;
      next_pc      = m_pc + 32'd4;
      fetch_q.push_back('{addr: m_pc, ret: m_ret, cyc: m_cyc});
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      tick();
      ifu_rsp_valid = 1'b0;
      tick();
      tick();
      do_reset(1);

      run_instr(32'h0030_0193, 1'b1, 1'b0, m_pc + 32'd4, 1, 0, 0, 0);
      tick();
      tick();
      done = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Multi-cycle control sequencer for the npc core. It owns the PC and runs each instruction through fetch, execute and optional memory access over valid/ready handshakes with the instruction-fetch and load/store units. It gates register-file and PC writes from the decoder/ALU datapath and halts on `ebreak` or a misaligned next PC. It also keeps 64-bit cycle and retired-instruction counters.

## Interface
- `RESET_PC`, 32'h80000000: PC value loaded on reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `ifu_req_valid`  out  1  fetch request valid.
- `ifu_req_addr`  out  32  fetch address (= `pc`).
- `ifu_req_ready`  in  1  IFU accepts request.
- `ifu_rsp_valid`  in  1  fetched instruction valid.
- `ifu_rsp_inst`  in  32  fetched instruction.
- `ifu_rsp_ready`  out  1  controller accepts instruction.
- `dec_reg_wen`  in  1  decoder: instruction writes rd.
- `dec_is_mem`  in  1  decoder: load/store.
- `next_pc`  in  32  datapath next PC (pc+4 or branch target).
- `lsu_req_valid`  out  1  memory request valid.
- `lsu_req_ready`  in  1  LSU accepts request.
- `lsu_rsp_valid`  in  1  LSU completion, one-cycle pulse.
- `inst`  out  32  latched current instruction, fed to decoder.
- `pc`  out  32  current PC.
- `rf_wen`  out  1  register-file write strobe.
- `halted`  out  1  sticky halt flag.
- `halt_err`  out  1  halt caused by misaligned `next_pc`.
- `cycle_cnt`  out  64  cycles since reset while not halted.
- `instret`  out  64  retired instructions.

## Operation
- States: FETCH, IWAIT, EXEC, MEM, MWAIT, HALT.
- **FETCH**
  - `ifu_req_valid`=1 with `ifu_req_addr`=`pc`.
  - Request is accepted when `ifu_req_ready`=1; then go to IWAIT.
- **IWAIT**
  - `ifu_rsp_ready`=1.
  - When `ifu_rsp_valid`=1, latch `inst`←`ifu_rsp_inst` and go to EXEC.
- **EXEC** (exactly one cycle; decoder sees the latched `inst`):
  - If `inst`==32'h00100073 (ebreak): `instret`++, no register-file or PC write, go to HALT.
  - Else if `next_pc[1:0]`≠0: set `halt_err`=1, no writes, no retire, go to HALT.
  - Else if `dec_is_mem`: go to MEM.
  - Else: `rf_wen`=`dec_reg_wen`, `pc`←`next_pc`, `instret`++, go to FETCH.
- **MEM**
  - `lsu_req_valid`=1.
  - When `lsu_req_ready`=1, go to MWAIT.
- **MWAIT**
  - On `lsu_rsp_valid`: `rf_wen`=`dec_reg_wen`, `pc`←`next_pc`, `instret`++, go to FETCH.
  - `next_pc` alignment was already checked in EXEC.
- **HALT**
  - Terminal: all request and strobe outputs are 0.
  - Only `rst` leaves HALT.
- Handshake rules:
  - Once a valid is asserted, it and its address stay stable until the matching ready arrives.
  - `ifu_rsp_valid` is held by the IFU until accepted. A response arriving in FETCH (same cycle as the request) is not accepted; it is taken in IWAIT the next cycle.
  - `lsu_rsp_valid` outside MWAIT is ignored.
- Counters:
  - `cycle_cnt` increments every non-reset cycle where state≠HALT.
  - Both counters are 64-bit and wrap modulo 2^64.

## Timing
- Reset:
  - `pc`=`RESET_PC`; state=FETCH.
  - `inst`=0, `halted`=0, `halt_err`=0, `cycle_cnt`=0, `instret`=0.
  - All valid/ready/strobe outputs are 0 during the reset cycle.
- The first `ifu_req_valid` is asserted in the first cycle after `rst` deasserts.
- Reset asserted in any state, including mid-handshake or HALT, restores the reset values the next cycle. Outstanding requests are abandoned.
- Minimum latencies with zero-wait memory:
  - ALU instruction: 3 cycles (FETCH, IWAIT, EXEC).
  - Memory instruction: 5 cycles (adds MEM, MWAIT).
- `rf_wen` and `pc` update are in the same cycle; the new `pc` is visible on `ifu_req_addr` in the following FETCH cycle.
- `halted` = (state==HALT) is registered. It rises the cycle after EXEC detects ebreak or misalignment.

## Structure
- Shared package `npc_pkg`:
  - State enum `ctrl_state_t`.
  - `NPC_RESET_PC` (32'h80000000).
  - `INST_EBREAK` (32'h00100073).
- Sub-module `npc_perf_cnt`: 64-bit counter with synchronous clear and enable, instantiated twice (cycles, instret).
- The PC register is held inside `npc_ctrl` and is not duplicated in the datapath.

## Test plan
- **Reset:** hold `rst` 2 cycles, release → `pc`=32'h80000000, `ifu_req_valid`=1 next cycle, both counters 0.
- **Three ALU instructions, zero-wait IFU,** `next_pc`=`pc`+4:
  - `pc` reaches 32'h8000000C after 9 cycles.
  - `instret`=3, `cycle_cnt`=9.
  - `rf_wen` pulses once per instruction.
- **IFU backpressure:** `ifu_req_ready` low for 4 cycles → `ifu_req_valid`/`addr` stable throughout; `inst` latched only on the `ifu_rsp_valid`&&`ifu_rsp_ready` cycle.
- **Load with LSU delays:** `lsu_req_ready` 2-cycle delay, `lsu_rsp_valid` 3 cycles later → single `rf_wen` in the response cycle; `pc`+4; `instret`+1.
- **ebreak:** `inst`=32'h00100073 → `halted`=1, `halt_err`=0, `instret` incremented, `pc` unchanged, `cycle_cnt` frozen, no further requests. Then `rst` → FETCH at `RESET_PC`.
- **Misalignment:** `next_pc`=32'h80000006 in EXEC → `halt_err`=1, `halted`=1, no `rf_wen`, `instret` unchanged.
